// File: rtl/mc_accumulator.sv
// Purpose   : Monte-Carlo payoff accumulator; sums accepted payoffs and their squares over a host-set sample count.
// Latency   : 2 cycles from an accepted PAYOFF to SUM_OUTPUT/SUM_SQUARE_OUTPUT/Current_Count; Status follows one edge later.
// Backpress : none on PAYOFF; SAMPLE_EN throttles the upstream generator, and valids arriving without room are dropped.
//
// Optional feature macro: ACC_OVERRUN_FLAG_EN (adds the sticky Overrun output).
//
// Ports:
//   clk                in   1   system clock, rising edge
//   nRESET             in   1   asynchronous active-low reset
//   Mode               in   1   run request (1 = run, 0 = idle/abort); a 0->1 edge starts a run
//   M_count            in  32   target sample count, latched at start
//   PAYOFF             in  16   unsigned payoff sample
//   PAYOFF_VALID       in   1   PAYOFF valid this cycle
//   SAMPLE_EN          out  1   enable to the upstream sample generator
//   SUM_OUTPUT         out 64   running sum of accepted payoffs
//   SUM_SQUARE_OUTPUT  out 64   running sum of squared accepted payoffs
//   Status             out  1   run complete
//   Current_Count      out 32   samples accumulated so far
//   Overrun            out  1   sticky discarded-sample flag (ACC_OVERRUN_FLAG_EN only)

module mc_accumulator (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        Mode,
    input  logic [31:0] M_count,
    input  logic [15:0] PAYOFF,
    input  logic        PAYOFF_VALID,
    output logic        SAMPLE_EN,
    output logic [63:0] SUM_OUTPUT,
    output logic [63:0] SUM_SQUARE_OUTPUT,
    output logic        Status,
    output logic [31:0] Current_Count
`ifdef ACC_OVERRUN_FLAG_EN
    ,
    output logic        Overrun
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        mode_d;
    logic        armed;
    logic [31:0] target;
    logic        s1_vld;
    logic [15:0] s1_val;
    logic [31:0] s1_sq;
    logic [31:0] payoff_sq;
    logic        start;
    logic        room;
    logic        accept;
    logic        commit;

    // After reset, Mode must be seen low before a rising edge counts, so a
    // host that leaves Mode high across a reset does not restart the run.
    assign start = (state == IDLE) && Mode && !mode_d && armed;

    // Room counts the stage-1 sample as already spoken for; 33-bit compare
    // keeps the sum from wrapping when target is near 2^32-1.
    assign room = ({1'b0, Current_Count} + {32'd0, s1_vld}) < {1'b0, target};

    // Gating on Mode drops the in-flight sample on the abort edge.
    assign accept = (state == RUN) && Mode && PAYOFF_VALID && room;
    assign commit = (state == RUN) && Mode && s1_vld;

    assign payoff_sq = {16'd0, PAYOFF} * {16'd0, PAYOFF};

    // State register
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (M_count == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!Mode) begin
                    state_nxt = IDLE;
                end else if ((Current_Count == target) && !s1_vld) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!Mode) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        SAMPLE_EN = 1'b0;
        Status    = 1'b0;
        case (state)
            RUN:     SAMPLE_EN = room;
            DONE:    Status    = 1'b1;
            default: ;
        endcase
    end

    // Edge detect, target latch and two-stage accumulation pipeline
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            mode_d            <= 1'b0;
            armed             <= 1'b0;
            target            <= 32'd0;
            s1_vld            <= 1'b0;
            s1_val            <= 16'd0;
            s1_sq             <= 32'd0;
            SUM_OUTPUT        <= 64'd0;
            SUM_SQUARE_OUTPUT <= 64'd0;
            Current_Count     <= 32'd0;
        end else begin
            mode_d <= Mode;
            armed  <= armed | !Mode;
            s1_vld <= accept;
            if (accept) begin
                s1_val <= PAYOFF;
                s1_sq  <= payoff_sq;
            end
            if (start) begin
                target            <= M_count;
                SUM_OUTPUT        <= 64'd0;
                SUM_SQUARE_OUTPUT <= 64'd0;
                Current_Count     <= 32'd0;
            end else if (commit) begin
                // (2^16-1)^2 * (2^32-1) < 2^64: these cannot wrap.
                SUM_OUTPUT        <= SUM_OUTPUT + {48'd0, s1_val};
                SUM_SQUARE_OUTPUT <= SUM_SQUARE_OUTPUT + {32'd0, s1_sq};
                Current_Count     <= Current_Count + 32'd1;
            end
        end
    end

`ifdef ACC_OVERRUN_FLAG_EN
    // Sticky until the next start: a valid arriving in DONE, or in RUN
    // without room, was thrown away.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            Overrun <= 1'b0;
        end else if (start) begin
            Overrun <= 1'b0;
        end else if (PAYOFF_VALID &&
                     ((state == DONE) || ((state == RUN) && !room))) begin
            Overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_accumulator.sv
// Bench for mc_accumulator: table of complete runs plus hand-written abort,
// restart and mid-run reset sequences. A model pushes expected running
// totals per accepted sample; a monitor pops them as Current_Count advances.

module tb_mc_accumulator;

    logic        clk = 1'b0;
    logic        nRESET;
    logic        Mode;
    logic [31:0] M_count;
    logic [15:0] PAYOFF;
    logic        PAYOFF_VALID;
    logic        SAMPLE_EN;
    logic [63:0] SUM_OUTPUT;
    logic [63:0] SUM_SQUARE_OUTPUT;
    logic        Status;
    logic [31:0] Current_Count;
`ifdef ACC_OVERRUN_FLAG_EN
    logic        Overrun;
`endif

    always #5 clk = ~clk;

    mc_accumulator dut (
        .clk               (clk),
        .nRESET            (nRESET),
        .Mode              (Mode),
        .M_count           (M_count),
        .PAYOFF            (PAYOFF),
        .PAYOFF_VALID      (PAYOFF_VALID),
        .SAMPLE_EN         (SAMPLE_EN),
        .SUM_OUTPUT        (SUM_OUTPUT),
        .SUM_SQUARE_OUTPUT (SUM_SQUARE_OUTPUT),
        .Status            (Status),
        .Current_Count     (Current_Count)
`ifdef ACC_OVERRUN_FLAG_EN
        ,
        .Overrun           (Overrun)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] cnt;
        logic [63:0] sum;
        logic [63:0] sq;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    typedef struct {
        logic [31:0]       m;
        int                n;
        logic [3:0][15:0]  pay;
        bit                gap;
        logic [63:0]       sum;
        logic [63:0]       sq;
        logic [31:0]       cnt;
        int                lat;
        bit                ovr;
    } vec_t;

    vec_t tbl[5];

    bit          model_run;
    logic [31:0] model_target;
    logic [31:0] model_acc;
    logic [63:0] model_sum;
    logic [63:0] model_sq;
    logic [31:0] prev_cnt = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pop one expected total each time the accumulated count steps by one.
    always @(negedge clk) begin
        if (nRESET && (Current_Count == prev_cnt + 32'd1)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_underflow: count stepped to %0d with nothing expected", Current_Count);
            end else begin
                mon_e = sb.pop_front();
                check("sb_cnt", 64'(Current_Count), 64'(mon_e.cnt));
                check("sb_sum", SUM_OUTPUT, mon_e.sum);
                check("sb_sq",  SUM_SQUARE_OUTPUT, mon_e.sq);
            end
        end
        prev_cnt = Current_Count;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_start(input logic [31:0] m);
        model_target = m;
        model_acc    = 32'd0;
        model_sum    = 64'd0;
        model_sq     = 64'd0;
        model_run    = (m != 32'd0);
        sb.delete();
    endtask

    task automatic start_run(input logic [31:0] m);
        M_count = m;
        Mode    = 1'b0;
        tick();
        Mode = 1'b1;
        model_start(m);
        tick();
    endtask

    task automatic send(input logic v, input logic [15:0] p);
        logic en;
        PAYOFF       = p;
        PAYOFF_VALID = v;
        en = model_run && (model_acc < model_target);
        check("sample_en", 64'(SAMPLE_EN), 64'(en));
        if (v && en) begin
            model_acc = model_acc + 32'd1;
            model_sum = model_sum + 64'(p);
            model_sq  = model_sq + 64'(p) * 64'(p);
            sb.push_back('{model_acc, model_sum, model_sq});
        end
        tick();
        PAYOFF_VALID = 1'b0;
        PAYOFF       = 16'd0;
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        int lat;
        lat = 0;
        while (!Status && lat < 20) begin
            send(1'b0, 16'd0);
            lat++;
        end
        check({name, "_done_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic set_vec(input int k, input logic [31:0] m, input int n,
                           input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] p2, input logic [15:0] p3,
                           input bit gap, input logic [63:0] sum, input logic [63:0] sq,
                           input logic [31:0] cnt, input int lat, input bit ovr);
        tbl[k].m   = m;
        tbl[k].n   = n;
        tbl[k].pay = {p3, p2, p1, p0};
        tbl[k].gap = gap;
        tbl[k].sum = sum;
        tbl[k].sq  = sq;
        tbl[k].cnt = cnt;
        tbl[k].lat = lat;
        tbl[k].ovr = ovr;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nRESET       = 1'b0;
        Mode         = 1'b0;
        M_count      = 32'd0;
        PAYOFF       = 16'd0;
        PAYOFF_VALID = 1'b0;
        model_start(32'd0);
        #1;
        check("rst_sum",    SUM_OUTPUT, 64'd0);
        check("rst_sq",     SUM_SQUARE_OUTPUT, 64'd0);
        check("rst_cnt",    64'(Current_Count), 64'd0);
        check("rst_status", 64'(Status), 64'd0);
        check("rst_en",     64'(SAMPLE_EN), 64'd0);
`ifdef ACC_OVERRUN_FLAG_EN
        check("rst_ovr",    64'(Overrun), 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        nRESET = 1'b1;
        tick();

        //      k  M  n   p0     p1   p2  p3     gap sum    sq                cnt lat ovr
        set_vec(0, 4, 4,  3,     5,   0,  65535, 0,  65543, 64'd4294836259,  4,  2,  0);
        set_vec(1, 0, 0,  0,     0,   0,  0,     0,  0,     64'd0,           0,  0,  0);
        set_vec(2, 3, 3,  10,    10,  10, 0,     1,  30,    64'd300,         3,  2,  0);
        set_vec(3, 2, 4,  100,   200, 7,  9,     0,  300,   64'd50000,       2,  0,  1);
        set_vec(4, 1, 1,  65535, 0,   0,  0,     0,  65535, 64'd4294836225,  1,  2,  0);

        for (int k = 0; k < 5; k++) begin
            start_run(tbl[k].m);
            for (int i = 0; i < tbl[k].n; i++) begin
                send(1'b1, tbl[k].pay[i]);
                if (tbl[k].gap && i != tbl[k].n - 1) send(1'b0, 16'd0);
            end
            wait_done(tbl[k].lat, $sformatf("v%0d", k));
            check($sformatf("v%0d_sum", k), SUM_OUTPUT, tbl[k].sum);
            check($sformatf("v%0d_sq", k),  SUM_SQUARE_OUTPUT, tbl[k].sq);
            check($sformatf("v%0d_cnt", k), 64'(Current_Count), 64'(tbl[k].cnt));
            check($sformatf("v%0d_en_done", k), 64'(SAMPLE_EN), 64'd0);
`ifdef ACC_OVERRUN_FLAG_EN
            check($sformatf("v%0d_ovr", k), 64'(Overrun), 64'(tbl[k].ovr));
`endif
            check($sformatf("v%0d_sb_left", k), 64'(sb.size()), 64'd0);
            Mode      = 1'b0;
            model_run = 1'b0;
            tick();
            check($sformatf("v%0d_idle_status", k), 64'(Status), 64'd0);
            check($sformatf("v%0d_idle_sum", k), SUM_OUTPUT, tbl[k].sum);
            check($sformatf("v%0d_idle_cnt", k), 64'(Current_Count), 64'(tbl[k].cnt));
        end

        // Abort after 5 accepts; M_count change mid-run must be ignored.
        start_run(32'd10);
        M_count = 32'd3;
        for (int i = 1; i <= 5; i++) send(1'b1, 16'(i));
        send(1'b0, 16'd0);
        send(1'b0, 16'd0);
        check("abort_pre_cnt", 64'(Current_Count), 64'd5);
        Mode      = 1'b0;
        model_run = 1'b0;
        tick();
        check("abort_status", 64'(Status), 64'd0);
        check("abort_cnt",    64'(Current_Count), 64'd5);
        check("abort_sum",    SUM_OUTPUT, 64'd15);
        check("abort_sq",     SUM_SQUARE_OUTPUT, 64'd55);
        check("abort_en",     64'(SAMPLE_EN), 64'd0);
        Mode = 1'b1;
        model_start(M_count);
        tick();
        check("restart_cnt", 64'(Current_Count), 64'd0);
        check("restart_sum", SUM_OUTPUT, 64'd0);
        check("restart_sq",  SUM_SQUARE_OUTPUT, 64'd0);
        send(1'b1, 16'd7);
        send(1'b1, 16'd8);
        send(1'b0, 16'd0);
        send(1'b0, 16'd0);
        check("partial_sum", SUM_OUTPUT, 64'd15);

        // 1->0->1 pulse: abort then fresh start with nothing carried over.
        Mode = 1'b0;
        tick();
        Mode = 1'b1;
        model_start(M_count);
        tick();
        check("pulse_cnt",    64'(Current_Count), 64'd0);
        check("pulse_sum",    SUM_OUTPUT, 64'd0);
        check("pulse_status", 64'(Status), 64'd0);
        for (int i = 0; i < 3; i++) send(1'b1, 16'd4);
        wait_done(2, "pulse");
        check("pulse_end_sum", SUM_OUTPUT, 64'd12);
        check("pulse_end_sq",  SUM_SQUARE_OUTPUT, 64'd48);
        Mode      = 1'b0;
        model_run = 1'b0;
        tick();

        // Reset mid-run at Current_Count = 7, Mode held high through it.
        start_run(32'd20);
        for (int i = 0; i < 8; i++) send(1'b1, 16'd2);
        check("mid_pre_cnt", 64'(Current_Count), 64'd7);
        nRESET = 1'b0;
        #2;
        sb.delete();
        model_run = 1'b0;
        check("mid_rst_sum",    SUM_OUTPUT, 64'd0);
        check("mid_rst_sq",     SUM_SQUARE_OUTPUT, 64'd0);
        check("mid_rst_cnt",    64'(Current_Count), 64'd0);
        check("mid_rst_status", 64'(Status), 64'd0);
        check("mid_rst_en",     64'(SAMPLE_EN), 64'd0);
        #3;
        nRESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("norestart_en",     64'(SAMPLE_EN), 64'd0);
            check("norestart_status", 64'(Status), 64'd0);
            check("norestart_cnt",    64'(Current_Count), 64'd0);
        end
        start_run(32'd2);
        send(1'b1, 16'd9);
        send(1'b1, 16'd9);
        wait_done(2, "post_rst");
        check("post_rst_sum", SUM_OUTPUT, 64'd18);
        check("post_rst_sq",  SUM_SQUARE_OUTPUT, 64'd162);
        Mode = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_accumulator.md
MC_ACCUMULATOR -- requirements
Module: mc_accumulator

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and nRESET.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  system clock; all state changes on its rising edge.
- nRESET  in  1  asynchronous active-low reset.
- Mode  in  1  run request from the host register block; 1 = run, 0 = idle/abort.
- M_count  in  32  target sample count from the host register block.
- PAYOFF  in  16  unsigned payoff sample from the upstream payoff pipeline.
- PAYOFF_VALID  in  1  PAYOFF is valid this cycle; no backpressure exists.
- SAMPLE_EN  out  1  enable to the upstream sample generator.
- SUM_OUTPUT  out  64  running sum of accepted payoffs.
- SUM_SQUARE_OUTPUT  out  64  running sum of squared accepted payoffs.
- Status  out  1  run complete.
- Current_Count  out  32  number of samples accumulated so far.
- Overrun  out  1  present only when ACC_OVERRUN_FLAG_EN is defined (see Configuration).

Function
REQ-003 The block SHALL implement an FSM with states IDLE, RUN and DONE, and SHALL register a delayed copy of Mode so that it can detect a 0->1 edge on Mode.
REQ-004 In IDLE, a Mode 0->1 edge SHALL, on the same edge:
- clear both sums and Current_Count;
- latch M_count into an internal target register;
- enter RUN.
REQ-005 If the latched target is 0, the block SHALL enter DONE instead of RUN and SHALL set Status to 1 on the next edge.
REQ-006 SAMPLE_EN SHALL be 1 only in RUN while (accepted count + in-flight samples) < target.
REQ-007 A sample SHALL be accepted only when the state is RUN, PAYOFF_VALID = 1, and (accepted count + in-flight) < target; all other valid samples SHALL be discarded.
REQ-008 The accumulation pipeline SHALL be two stages:
- Stage 1, at the acceptance edge N: register PAYOFF and its 32-bit unsigned square.
- Stage 2, at edge N+1: add the zero-extended value to SUM_OUTPUT and the zero-extended square to SUM_SQUARE_OUTPUT, and increment Current_Count.
REQ-009 The 64-bit accumulators SHALL NOT wrap: (2^16-1)^2 x (2^32-1) < 2^64, so no saturation logic is required.
REQ-010 When Current_Count reaches the target and no sample is in flight, the FSM SHALL enter DONE on that edge and set Status = 1.
REQ-011 In DONE:
- SAMPLE_EN SHALL be 0;
- the sums and Current_Count SHALL hold their values;
- the state SHALL remain DONE while Mode = 1.
REQ-012 Mode = 0 in RUN or DONE SHALL return the FSM to IDLE on the next edge and clear Status; the sums and Current_Count SHALL hold for host readback, and any in-flight stage-1 sample SHALL be dropped.
REQ-013 In IDLE, Status SHALL be 0 and SAMPLE_EN SHALL be 0.
REQ-014 A change on M_count during RUN SHALL have no effect until the next start.
REQ-015 Mode pulsing 1->0->1 within 2 cycles SHALL produce an abort followed by a fresh start; no partial state SHALL carry over into the new run.

Reset
REQ-016 nRESET low SHALL asynchronously force:
- state to IDLE;
- SUM_OUTPUT, SUM_SQUARE_OUTPUT, Current_Count, the target register and the pipeline registers to 0;
- Status, SAMPLE_EN, the delayed Mode copy, and Overrun (if present) to 0.
REQ-017 A reset asserted mid-run SHALL discard all partial results; after release, the block SHALL require a new Mode 0->1 edge to start.

Configuration
REQ-018 With macro ACC_OVERRUN_FLAG_EN defined:
- the output Overrun SHALL exist;
- Overrun SHALL be set to 1 when PAYOFF_VALID = 1 arrives in DONE, or in RUN when the sample is discarded under REQ-007;
- Overrun SHALL be sticky until the next start or reset.
REQ-019 Without ACC_OVERRUN_FLAG_EN, the Overrun port and its logic SHALL be absent and the rest of the behaviour SHALL be identical.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- M_count = 4, Mode 0->1, PAYOFF = 3,5,0,65535 with valid every cycle -> SUM = 65543, SUM_SQUARE = 4294836259, Current_Count = 4, Status = 1 two edges after the last accept.
- M_count = 0, Mode 0->1 -> DONE, Status = 1, sums = 0, SAMPLE_EN never asserts.
- M_count = 3, valid on alternate cycles with PAYOFF = 10 -> SUM = 30, SUM_SQUARE = 300, Status = 1 after the third accept.
- M_count = 10, Mode drops after 5 accepts -> IDLE, Status = 0, Current_Count = 5 held, SUM holds the partial value; Mode 0->1 again -> all outputs restart from 0.
- nRESET pulse mid-run with Current_Count = 7 -> all outputs 0 immediately; no restart without a Mode edge.
- ACC_OVERRUN_FLAG_EN defined, M_count = 2, 4 consecutive valids -> Current_Count = 2, Overrun = 1; with the macro undefined -> same sums, and no Overrun port.
